// File: rtl/execute_stage_if.sv
// execute_stage_if: register-access -> execute -> memory-access bundle, plus the
// writeback-type and data-memory encodings shared by the stage and its neighbours.
`ifndef WB_HICCUP
`define WB_HICCUP 2'd0
`endif
`ifndef WB_ALU
`define WB_ALU 2'd1
`endif
`ifndef WB_LOAD
`define WB_LOAD 2'd2
`endif
`ifndef DM_NONE
`define DM_NONE 2'd0
`endif
interface execute_stage_if;
  logic [31:0] data_a, data_b, rs2_value, immediate_value, pc;
  logic [4:0] execute_instruction, destination_register_number;
  logic condition_branch, taken, load_signed;
  logic [1:0] read_status, write_status, write_back_type;
  logic [31:0] result_output, rs2_value_output, execute_result_forward, redirect_pc;
  logic [1:0] read_status_output, write_status_output, write_back_type_output;
  logic load_signed_output, execute_forward_enable, mispredict, stall;
  logic [4:0] destination_register_number_output, execute_destination_register_number;
  modport slave (
    input data_a, data_b, rs2_value, immediate_value, pc, execute_instruction,
          destination_register_number, condition_branch, taken, load_signed,
          read_status, write_status, write_back_type,
    output result_output, rs2_value_output, execute_result_forward, redirect_pc,
           read_status_output, write_status_output, write_back_type_output,
           load_signed_output, execute_forward_enable, mispredict, stall,
           destination_register_number_output, execute_destination_register_number
  );
  modport master (
    output data_a, data_b, rs2_value, immediate_value, pc, execute_instruction,
           destination_register_number, condition_branch, taken, load_signed,
           read_status, write_status, write_back_type,
    input result_output, rs2_value_output, execute_result_forward, redirect_pc,
          read_status_output, write_status_output, write_back_type_output,
          load_signed_output, execute_forward_enable, mispredict, stall,
          destination_register_number_output, execute_destination_register_number
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: ALU/compare/branch resolution plus a shift-add multiplier that stalls upstream.
// Define EX_BRANCH_STATS_EN to add the branch_count/mispredict_count outputs.
module execute_stage #(
  parameter int XLEN = 32,
  parameter int MUL_CYCLES = 32
) (
  input logic clk,
  input logic reset,
  execute_stage_if.slave bus
`ifdef EX_BRANCH_STATS_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
`endif
);
  localparam int CW = $clog2(MUL_CYCLES);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_next;
  logic [XLEN-1:0] w_a, w_b, w_alu, r_mplier, r_m_rs2, r_result, r_rs2, r_rpc;
  logic [2*XLEN-1:0] r_acc, r_mcand, w_prod;
  logic [CW-1:0] r_cnt;
  logic [4:0] w_sh, r_m_rd, r_rd;
  logic [1:0] r_m_rs, r_m_ws, r_m_wb, r_rs, r_ws, r_wb;
  logic w_bubble, w_is_mul, w_start, w_done, w_br, w_mis;
  logic w_eq, w_lt, w_ltu, r_mhi, r_m_ls, r_ls, r_fwd, r_mis;
  assign w_a = bus.data_a;
  assign w_b = bus.data_b;
  assign w_sh = bus.data_b[4:0];
  assign w_eq = w_a == w_b;
  assign w_lt = $signed(w_a) < $signed(w_b);
  assign w_ltu = w_a < w_b;
  always_comb begin
    w_alu = '0;
    case (bus.execute_instruction)
      5'd0: w_alu = w_a + w_b;
      5'd1: w_alu = w_a - w_b;
      5'd2: w_alu = w_a << w_sh;
      5'd3: w_alu = {{(XLEN-1){1'b0}}, w_lt};
      5'd4: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      5'd5: w_alu = w_a ^ w_b;
      5'd6: w_alu = w_a >> w_sh;
      5'd7: w_alu = $signed(w_a) >>> w_sh;
      5'd8: w_alu = w_a | w_b;
      5'd9: w_alu = w_a & w_b;
      5'd10: w_alu = {{(XLEN-1){1'b0}}, w_eq};
      5'd11: w_alu = {{(XLEN-1){1'b0}}, !w_eq};
      5'd12: w_alu = {{(XLEN-1){1'b0}}, w_lt};
      5'd13: w_alu = {{(XLEN-1){1'b0}}, !w_lt};
      5'd14: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      5'd15: w_alu = {{(XLEN-1){1'b0}}, !w_ltu};
      default: w_alu = '0;
    endcase
  end
  // One multiplier bit per BUSY cycle; w_prod is the accumulator after this cycle's step.
  assign w_prod = r_acc + (r_mplier[0] ? r_mcand : '0);
  always_comb begin
    w_bubble = bus.write_back_type == `WB_HICCUP;
    w_is_mul = bus.execute_instruction == 5'd16 || bus.execute_instruction == 5'd17;
    w_start = r_state == IDLE && w_is_mul && !w_bubble;
    w_done = r_state == BUSY && r_cnt == CW'(MUL_CYCLES - 1);
    w_br = r_state == IDLE && !w_start && bus.condition_branch && !w_bubble;
    w_mis = w_br && (w_alu[0] != bus.taken);
    w_state_next = w_start ? BUSY : w_done ? IDLE : r_state;
  end
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_state_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_mhi <= 1'b0;
      {r_m_rs2, r_m_rs, r_m_ws, r_m_ls, r_m_rd, r_m_wb} <= '0;
      r_result <= '0;
      r_rs2 <= '0;
      r_rs <= '0;
      r_ws <= `DM_NONE;
      r_ls <= 1'b0;
      r_rd <= '0;
      r_wb <= `WB_HICCUP;
      r_fwd <= 1'b0;
      r_mis <= 1'b0;
      r_rpc <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_mcand <= {{XLEN{1'b0}}, w_a};
      r_mplier <= w_b;
      r_mhi <= bus.execute_instruction == 5'd17;
      {r_m_rs2, r_m_rs, r_m_ws, r_m_ls, r_m_rd, r_m_wb} <= {bus.rs2_value, bus.read_status,
        bus.write_status, bus.load_signed, bus.destination_register_number, bus.write_back_type};
      r_wb <= `WB_HICCUP;
      r_ws <= `DM_NONE;
      r_fwd <= 1'b0;
      r_mis <= 1'b0;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_prod;
      r_mcand <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_done) begin
        r_result <= r_mhi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        {r_rs2, r_rs, r_ws, r_ls, r_rd, r_wb} <= {r_m_rs2, r_m_rs, r_m_ws, r_m_ls, r_m_rd, r_m_wb};
        r_fwd <= r_m_wb == `WB_ALU && r_m_rd != 5'd0;
      end
    end else begin
      r_result <= w_alu;
      r_rs2 <= bus.rs2_value;
      r_rs <= bus.read_status;
      r_ws <= w_bubble ? `DM_NONE : bus.write_status;
      r_ls <= bus.load_signed;
      r_rd <= bus.destination_register_number;
      r_wb <= bus.write_back_type;
      r_fwd <= !w_bubble && bus.write_back_type == `WB_ALU && bus.destination_register_number != 5'd0;
      r_mis <= w_mis;
      if (w_br) r_rpc <= w_alu[0] ? bus.pc + bus.immediate_value : bus.pc + 32'd4;
    end
  end
`ifdef EX_BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count <= '0;
      mispredict_count <= '0;
    end else begin
      branch_count <= branch_count + {31'd0, w_br};
      mispredict_count <= mispredict_count + {31'd0, w_mis};
    end
  end
`endif
  assign bus.result_output = r_result;
  assign bus.execute_result_forward = r_result;
  assign bus.rs2_value_output = r_rs2;
  assign bus.read_status_output = r_rs;
  assign bus.write_status_output = r_ws;
  assign bus.load_signed_output = r_ls;
  assign bus.destination_register_number_output = r_rd;
  assign bus.execute_destination_register_number = r_rd;
  assign bus.write_back_type_output = r_wb;
  assign bus.execute_forward_enable = r_fwd;
  assign bus.mispredict = r_mis;
  assign bus.redirect_pc = r_rpc;
  assign bus.stall = r_state == BUSY;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against a behavioural model.
`ifndef WB_HICCUP
`define WB_HICCUP 2'd0
`endif
`ifndef WB_ALU
`define WB_ALU 2'd1
`endif
`ifndef DM_NONE
`define DM_NONE 2'd0
`endif
module tb_execute_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int exp_bc = 0;
  int exp_mc = 0;
  execute_stage_if bus ();
`ifdef EX_BRANCH_STATS_EN
  logic [31:0] branch_count, mispredict_count;
  execute_stage dut (.clk(clk), .reset(reset), .bus(bus),
                     .branch_count(branch_count), .mispredict_count(mispredict_count));
`else
  execute_stage dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, sx, t;
    logic slt, ult;
    int sh;
    p = {32'd0, a} * {32'd0, b};
    sx = {{32{a[31]}}, a};
    sh = int'(b[4:0]);
    slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    ult = a < b;
    t = sx >> sh;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3, 12: return slt ? 32'd1 : 32'd0;
      4, 14: return ult ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return t[31:0];
      8: return a | b;
      9: return a & b;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return (a != b) ? 32'd1 : 32'd0;
      13: return slt ? 32'd0 : 32'd1;
      15: return ult ? 32'd0 : 32'd1;
      16: return p[31:0];
      17: return p[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cb, input logic tk, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [1:0] wb, input logic [4:0] rd);
    bus.execute_instruction = op;
    bus.data_a = a;
    bus.data_b = b;
    bus.condition_branch = cb;
    bus.taken = tk;
    bus.pc = pc;
    bus.immediate_value = imm;
    bus.write_back_type = wb;
    bus.destination_register_number = rd;
    bus.rs2_value = $urandom;
    bus.read_status = 2'($urandom);
    bus.write_status = 2'($urandom);
    bus.load_signed = 1'($urandom);
  endtask

  task automatic drive_rand();
    drive(5'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom,
          2'($urandom), 5'($urandom));
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cb, input logic tk, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [1:0] wb, input logic [4:0] rd);
    logic [31:0] r, rs2;
    logic [1:0] rs, ws;
    logic ls, bub, mul, mis, fwd;
    drive(op, a, b, cb, tk, pc, imm, wb, rd);
    rs2 = bus.rs2_value;
    rs = bus.read_status;
    ws = bus.write_status;
    ls = bus.load_signed;
    r = ref_alu(op, a, b);
    bub = wb == `WB_HICCUP;
    mul = (op == 5'd16 || op == 5'd17) && !bub;
    mis = cb && !bub && !mul && (r[0] != tk);
    fwd = !bub && wb == `WB_ALU && rd != 5'd0;
    if (cb && !bub && !mul) begin
      exp_bc++;
      if (mis) exp_mc++;
    end
    @(posedge clk); #1;
    if (mul) begin
      for (int i = 0; i < 32; i++) begin
        chk("mul_stall", 32'(bus.stall), 32'd1);
        if (i == 0) begin
          chk("mul_bubble_wb", 32'(bus.write_back_type_output), 32'(`WB_HICCUP));
          chk("mul_bubble_fwd", 32'(bus.execute_forward_enable), 32'd0);
        end
        drive_rand();
        @(posedge clk); #1;
      end
      chk("mul_stall_end", 32'(bus.stall), 32'd0);
    end else begin
      chk("stall", 32'(bus.stall), 32'd0);
    end
    chk("mispredict", 32'(bus.mispredict), 32'(mis));
    chk("fwd_en", 32'(bus.execute_forward_enable), 32'(fwd));
    chk("wb_type", 32'(bus.write_back_type_output), 32'(wb));
    chk("wr_status", 32'(bus.write_status_output), bub ? 32'(`DM_NONE) : 32'(ws));
    if (!bub) begin
      chk("result", bus.result_output, r);
      chk("fwd_value", bus.execute_result_forward, r);
      chk("rd", 32'(bus.destination_register_number_output), 32'(rd));
      chk("fwd_rd", 32'(bus.execute_destination_register_number), 32'(rd));
      chk("rs2", bus.rs2_value_output, rs2);
      chk("rd_status", 32'(bus.read_status_output), 32'(rs));
      chk("load_signed", 32'(bus.load_signed_output), 32'(ls));
    end
    if (mis) chk("redirect", bus.redirect_pc, r[0] ? pc + imm : pc + 32'd4);
  endtask

  initial begin
    logic [4:0] op;
    logic [1:0] wb;
    logic cb;
    drive(5'd0, 0, 0, 1'b0, 1'b0, 0, 0, `WB_HICCUP, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_mis", 32'(bus.mispredict), 32'd0);
    chk("rst_rpc", bus.redirect_pc, 32'd0);
    chk("rst_result", bus.result_output, 32'd0);
    chk("rst_wb", 32'(bus.write_back_type_output), 32'(`WB_HICCUP));
    chk("rst_ws", 32'(bus.write_status_output), 32'(`DM_NONE));
    chk("rst_fwd", 32'(bus.execute_forward_enable), 32'd0);
    reset = 1'b0;
    // Reset lands while the multiplier is mid-sequence (count 10).
    drive(5'd16, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0, 1'b0, 0, 0, `WB_ALU, 5'd3);
    @(posedge clk); #1;
    drive(5'd0, 0, 0, 1'b0, 1'b0, 0, 0, `WB_HICCUP, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_mul_stall", 32'(bus.stall), 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mrst_stall", 32'(bus.stall), 32'd0);
    chk("mrst_wb", 32'(bus.write_back_type_output), 32'(`WB_HICCUP));
    chk("mrst_fwd", 32'(bus.execute_forward_enable), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_result", bus.result_output, 32'd0);
      chk("mrst_no_stall", 32'(bus.stall), 32'd0);
    end
`ifdef EX_BRANCH_STATS_EN
    chk("rst_bc", branch_count, 32'd0);
    chk("rst_mc", mispredict_count, 32'd0);
`endif
    exp_bc = 0;
    exp_mc = 0;
    do_op(5'd10, 7, 7, 1'b1, 1'b0, 32'h100, 32'h20, `WB_HICCUP + 2'd3, 5'd0);
    chk("eq_mis_lit", 32'(bus.mispredict), 32'd1);
    chk("eq_rpc_lit", bus.redirect_pc, 32'h120);
    do_op(5'd10, 7, 7, 1'b1, 1'b1, 32'h100, 32'h20, `WB_HICCUP + 2'd3, 5'd0);
    chk("eq_taken_lit", 32'(bus.mispredict), 32'd0);
    do_op(5'd11, 7, 7, 1'b1, 1'b0, 32'h200, 32'h40, `WB_HICCUP + 2'd3, 5'd0);
`ifdef EX_BRANCH_STATS_EN
    chk("bc_three", branch_count, 32'd3);
    chk("mc_one", mispredict_count, 32'd1);
`endif
    do_op(5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0, 0, `WB_ALU, 5'd5);
    chk("add_wrap_lit", bus.result_output, 32'd0);
    chk("add_fwd_lit", 32'(bus.execute_forward_enable), 32'd1);
    do_op(5'd7, 32'h8000_0000, 32'h21, 1'b0, 1'b0, 0, 0, `WB_ALU, 5'd6);
    chk("sra_lit", bus.result_output, 32'hC000_0000);
    do_op(5'd4, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, `WB_ALU, 5'd7);
    chk("sltu_lit", bus.result_output, 32'd1);
    do_op(5'd25, 32'h55, 32'h66, 1'b0, 1'b0, 0, 0, `WB_ALU, 5'd8);
    chk("op25_lit", bus.result_output, 32'd0);
    do_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, `WB_ALU, 5'd9);
    chk("mulhu_lit", bus.result_output, 32'hFFFF_FFFE);
    do_op(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, `WB_ALU, 5'd9);
    chk("mul_lit", bus.result_output, 32'h0000_0001);
    do_op(5'd0, 32'd3, 32'd4, 1'b0, 1'b0, 0, 0, `WB_ALU, 5'd0);
    chk("rd0_fwd_lit", 32'(bus.execute_forward_enable), 32'd0);
    do_op(5'd0, 32'd3, 32'd4, 1'b1, 1'b0, 0, 0, `WB_HICCUP, 5'd4);
    chk("bubble_fwd_lit", 32'(bus.execute_forward_enable), 32'd0);
    for (int i = 0; i < 200; i++) begin
      op = 5'($urandom);
      if ($urandom_range(0, 3) != 0 && op >= 5'd16) op = 5'($urandom_range(0, 15));
      wb = 2'($urandom);
      cb = 1'($urandom);
      if (op == 5'd16 || op == 5'd17) begin
        wb = 2'($urandom_range(1, 3));
        cb = 1'b0;
      end
      do_op(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
            cb, 1'($urandom), $urandom, $urandom, wb, 5'($urandom));
    end
`ifdef EX_BRANCH_STATS_EN
    chk("bc_model", branch_count, 32'(exp_bc));
    chk("mc_model", mispredict_count, 32'(exp_mc));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
